// File: rtl/pipe_pkg.sv
// Shared defaults and helpers for the pipeline register chain.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: default stage count / payload / counter widths, occupancy width helper.
package pipe_pkg;

  localparam int unsigned NUM_STAGES_DEF = 4;
  localparam int unsigned DATA_W_DEF     = 256;
  localparam int unsigned CNT_W_DEF      = 32;

  // Width needed to count 0..n set valid bits.
  function automatic int unsigned occ_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: valid bit plus payload register.
// Latency: 1 cycle from i_load/i_d to o_valid/o_q.
// Backpressure: holds contents whenever i_load is low and i_kill is low.
// Ports: i_kill clears the stage, i_load opens it, i_inv says whether the
// incoming beat is real; o_valid/o_q are the registered stage contents.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              core_clk,
  input  logic              core_rst,
  input  logic              i_kill,
  input  logic              i_load,
  input  logic              i_inv,
  input  logic [DATA_W-1:0] i_d,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_q
);

  logic              r_valid;
  logic [DATA_W-1:0] r_q;

  // Kill beats load; a load with no incoming beat leaves a zeroed bubble so
  // stale payload never lingers behind an invalid stage.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      r_valid <= 1'b0;
      r_q     <= '0;
    end else if (i_kill) begin
      r_valid <= 1'b0;
      r_q     <= '0;
    end else if (i_load) begin
      r_valid <= i_inv;
      r_q     <= i_inv ? i_d : '0;
    end
  end

  assign o_valid = r_valid;
  assign o_q     = r_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// In-order pipeline register chain with per-stage valid and collapsing bubbles.
// Latency: item accepted at cycle t sits in stage k at t+1+k; one item/cycle.
// Backpressure: per stage; a stalled stage only blocks younger full stages.
// Ports: in_valid/in_ready feed stage 0; stage_d/stage_q are per-stage payload
// slices (0 = youngest); hold/flush_vec per stage; out_ready drains the oldest;
// stage_valid/stage_adv/out_valid/out_fire/occupancy/retire_cnt are status.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int unsigned NUM_STAGES = NUM_STAGES_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic                             core_clk,
  input  logic                             core_rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_STAGES*DATA_W-1:0]     stage_d,
  input  logic [NUM_STAGES-1:0]            hold,
  input  logic [NUM_STAGES-1:0]            flush_vec,
  input  logic                             out_ready,
  output logic [NUM_STAGES*DATA_W-1:0]     stage_q,
  output logic [NUM_STAGES-1:0]            stage_valid,
  output logic [NUM_STAGES-1:0]            stage_adv,
  output logic                             out_valid,
  output logic                             out_fire,
  output logic [occ_w(NUM_STAGES)-1:0]     occupancy,
  output logic [CNT_W-1:0]                 retire_cnt
);

  localparam int unsigned OCC_W = occ_w(NUM_STAGES);
  localparam int          LAST  = int'(NUM_STAGES) - 1;

  logic [NUM_STAGES-1:0] w_valid;
  logic [NUM_STAGES-1:0] w_kill;
  logic [NUM_STAGES-1:0] w_adv;
  logic [NUM_STAGES-1:0] w_load;
  logic [NUM_STAGES-1:0] w_inv;
  logic [OCC_W-1:0]      w_occ;
  logic [CNT_W-1:0]      r_retire_cnt;

  // Kill and ready both ripple from the oldest stage toward stage 0. Only
  // registered valid, hold, flush_vec and out_ready feed this chain, so
  // in_ready never depends on in_valid or stage_d.
  always_comb begin
    w_kill       = '0;
    w_adv        = '0;
    w_load       = '0;
    w_kill[LAST] = flush_vec[LAST];
    w_adv[LAST]  = w_valid[LAST] & ~hold[LAST] & ~w_kill[LAST] & out_ready;
    w_load[LAST] = ~w_valid[LAST] | w_adv[LAST];
    for (int k = LAST - 1; k >= 0; k--) begin
      w_kill[k] = flush_vec[k] | w_kill[k+1];
      w_adv[k]  = w_valid[k] & ~hold[k] & ~w_kill[k] & w_load[k+1];
      w_load[k] = ~w_valid[k] | w_adv[k];
    end
  end

  // A killed or held younger stage offers a bubble to the next older stage.
  assign w_inv = {w_valid[NUM_STAGES-2:0] & ~hold[NUM_STAGES-2:0] & ~w_kill[NUM_STAGES-2:0],
                  in_valid};

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    pipe_stage_reg #(
      .DATA_W (DATA_W)
    ) u_stage (
      .core_clk (core_clk),
      .core_rst (core_rst),
      .i_kill   (w_kill[g]),
      .i_load   (w_load[g]),
      .i_inv    (w_inv[g]),
      .i_d      (stage_d[g*DATA_W +: DATA_W]),
      .o_valid  (w_valid[g]),
      .o_q      (stage_q[g*DATA_W +: DATA_W])
    );
  end

  always_comb begin
    w_occ = '0;
    for (int k = 0; k < int'(NUM_STAGES); k++) begin
      w_occ = w_occ + OCC_W'(w_valid[k]);
    end
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      r_retire_cnt <= '0;
    end else if (w_adv[LAST]) begin
      r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  assign in_ready    = w_load[0];
  assign stage_valid = w_valid;
  assign stage_adv   = w_adv;
  assign out_valid   = w_valid[LAST];
  assign out_fire    = w_adv[LAST];
  assign occupancy   = w_occ;
  assign retire_cnt  = r_retire_cnt;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain with N=4, W=8.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_pipe_stage_chain;

  logic        core_clk;
  logic        core_rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  d0;
  logic [31:0] stage_d;
  logic [3:0]  hold;
  logic [3:0]  flush_vec;
  logic        out_ready;
  logic [31:0] stage_q;
  logic [3:0]  stage_valid;
  logic [3:0]  stage_adv;
  logic        out_valid;
  logic        out_fire;
  logic [2:0]  occupancy;
  logic [31:0] retire_cnt;

  int total;
  int bad;
  logic [7:0] sb[$];

  // Downstream "logic" is identity: stage k takes stage k-1's payload.
  assign stage_d = {stage_q[23:0], d0};

  pipe_stage_chain #(
    .NUM_STAGES (4),
    .DATA_W     (8),
    .CNT_W      (32)
  ) dut (
    .core_clk    (core_clk),
    .core_rst    (core_rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .stage_d     (stage_d),
    .hold        (hold),
    .flush_vec   (flush_vec),
    .out_ready   (out_ready),
    .stage_q     (stage_q),
    .stage_valid (stage_valid),
    .stage_adv   (stage_adv),
    .out_valid   (out_valid),
    .out_fire    (out_fire),
    .occupancy   (occupancy),
    .retire_cnt  (retire_cnt)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: every retirement must match the oldest expected payload.
  initial begin
    forever begin
      @(negedge core_clk);
      if (!core_rst && out_fire === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_retire: got %0h want none", stage_q[31:24]);
        end else begin
          chk("retire_data", 64'(stage_q[31:24]), 64'(sb.pop_front()));
        end
      end
    end
  end

  // One cycle: drive inputs just after the edge, check handshake outputs,
  // optionally record the beat as one that will retire, then advance.
  task automatic cyc(input logic iv, input logic [7:0] d, input logic ordy,
                     input logic [3:0] hd, input logic [3:0] fl,
                     input logic exp_rdy, input logic push, input logic exp_fire);
    in_valid  = iv;
    d0        = d;
    out_ready = ordy;
    hold      = hd;
    flush_vec = fl;
    #2;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_fire", 64'(out_fire), 64'(exp_fire));
    if (push) sb.push_back(d);
    @(posedge core_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    total     = 0;
    bad       = 0;
    core_rst  = 1'b1;
    in_valid  = 1'b0;
    d0        = 8'h00;
    hold      = 4'h0;
    flush_vec = 4'h0;
    out_ready = 1'b1;
    repeat (2) @(posedge core_clk);
    #1;
    core_rst = 1'b0;
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_valid", 64'(stage_valid), 64'h0);
    chk("rst_q", 64'(stage_q), 64'h0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_retire", 64'(retire_cnt), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    @(posedge core_clk);
    #1;

    // Streaming 0x11..0x16: first fire 4 cycles after the first accept.
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 8'h11 + 8'(i), 1'b1, 4'h0, 4'h0, 1'b1, 1'b1, (i >= 4));
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 8'h00, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("stream_retire", 64'(retire_cnt), 64'd6);
    chk("stream_occ", 64'(occupancy), 64'd0);

    // Bubble collapse: stages 1..3 full, stage 0 empty, sink stalled.
    cyc(1'b1, 8'hA1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 8'hA2, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 8'hA3, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("bubble_valid", 64'(stage_valid), 64'b1110);
    cyc(1'b1, 8'hA0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
    chk("bubble_occ", 64'(occupancy), 64'd4);
    cyc(1'b1, 8'hB0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("full_q", 64'(stage_q), 64'hA1A2A3A0);

    // Hold stage 2 for three cycles: stage 3 drains once, then bubble.
    cyc(1'b1, 8'hB0, 1'b1, 4'b0100, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("hold1_valid", 64'(stage_valid), 64'b0111);
    chk("hold1_q", 64'(stage_q), 64'h00A2A3A0);
    cyc(1'b1, 8'hB0, 1'b1, 4'b0100, 4'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hB0, 1'b1, 4'b0100, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("hold3_q", 64'(stage_q), 64'h00A2A3A0);
    cyc(1'b0, 8'h00, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("hold_retire", 64'(retire_cnt), 64'd10);

    // Flush stage 2 with all full: only C1 in stage 3 retires.
    cyc(1'b1, 8'hC1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 8'hC2, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'hC3, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'hC4, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("flush_pre_valid", 64'(stage_valid), 64'b1111);
    cyc(1'b1, 8'hDD, 1'b1, 4'h0, 4'b0100, 1'b0, 1'b0, 1'b1);
    chk("flush_valid", 64'(stage_valid), 64'h0);
    chk("flush_q", 64'(stage_q), 64'h0);
    chk("flush_retire", 64'(retire_cnt), 64'd11);
    // Beat accepted while stage 0 is killed is discarded.
    cyc(1'b1, 8'hEE, 1'b1, 4'h0, 4'b0001, 1'b1, 1'b0, 1'b0);
    chk("drop_valid", 64'(stage_valid), 64'h0);
    chk("drop_q", 64'(stage_q), 64'h0);

    // Flush and hold on the last stage with sink ready: no fire.
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 8'hD1 + 8'(i), 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b1, 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0);
    chk("fh_valid", 64'(stage_valid), 64'h0);
    chk("fh_q", 64'(stage_q), 64'h0);
    chk("fh_retire", 64'(retire_cnt), 64'd11);

    // Asynchronous reset with four items in flight.
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 8'hE1 + 8'(i), 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_occ", 64'(occupancy), 64'd4);
    @(negedge core_clk);
    #1;
    core_rst = 1'b1;
    #1;
    chk("arst_valid", 64'(stage_valid), 64'h0);
    chk("arst_q", 64'(stage_q), 64'h0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_retire", 64'(retire_cnt), 64'd0);
    @(posedge core_clk);
    #1;
    core_rst = 1'b0;
    cyc(1'b1, 8'hF1, 1'b1, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 8'h00, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1);
    chk("post_rst_retire", 64'(retire_cnt), 64'd1);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
